stoch_sobel_x_engine: RTL and testbench

- Stochastic-computing Sobel-X responder. It sits on the core side of the start/done window handshake; a raster scanner or bench is the initiator that presents the 8 neighbour pixels.
- It converts binary pixels to 256-bit unipolar streams from shared LFSRs, forms a weighted column difference with MUX/XOR logic, and counts ones back to an 8-bit edge magnitude.
- It pulses done when z_bin is valid. Full turnaround fits the 261-cycle window budget the scanner allots per pixel.

---
 rtl/stoch_sobel_x_engine_if.sv | 34 +++
 rtl/stoch_sobel_x_engine.sv | 143 ++++++++++++++
 tb/tb_stoch_sobel_x_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/stoch_sobel_x_engine_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stoch_sobel_x_engine_if : start/done window handshake bundle      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface stoch_sobel_x_engine_if;
  logic       start;
  logic [7:0] pixel_1_bin;
  logic [7:0] pixel_2_bin;
  logic [7:0] pixel_3_bin;
  logic [7:0] pixel_4_bin;
  logic [7:0] pixel_6_bin;
  logic [7:0] pixel_7_bin;
  logic [7:0] pixel_8_bin;
  logic [7:0] pixel_9_bin;
  logic [7:0] z_bin;
  logic       done;
  logic       busy;

  modport master (
    output start,
    output pixel_1_bin, pixel_2_bin, pixel_3_bin, pixel_4_bin,
    output pixel_6_bin, pixel_7_bin, pixel_8_bin, pixel_9_bin,
    input  z_bin, done, busy
  );

  modport slave (
    input  start,
    input  pixel_1_bin, pixel_2_bin, pixel_3_bin, pixel_4_bin,
    input  pixel_6_bin, pixel_7_bin, pixel_8_bin, pixel_9_bin,
    output z_bin, done, busy
  );
endinterface
`default_nettype wire

// File: rtl/stoch_sobel_x_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stoch_sobel_x_engine : stochastic Sobel-X edge magnitude core     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module stoch_sobel_x_engine #(
  parameter int         STREAM_LEN = 256,
  parameter logic [7:0] DATA_SEED  = 8'h01,
  parameter logic [7:0] SEL_SEED   = 8'hA5
) (
  input  wire logic              clk,
  input  wire logic              reset,
  stoch_sobel_x_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [8:0] c_last_cycle = 9'(STREAM_LEN - 1);

  state_t     r_state;
  state_t     w_next_state;

  logic [7:0] r_p1, r_p2, r_p3, r_p4, r_p6, r_p7, r_p8, r_p9;
  logic [7:0] r_data_lfsr;
  logic [7:0] r_sel_lfsr;
  logic [8:0] r_ones;
  logic [8:0] r_cycle;
  logic [7:0] r_z;
  logic       r_done;
  logic       r_busy;

  logic       w_pb;
  logic       w_nb;
  logic       w_out_bit;
  logic       w_accept;
  logic       w_unused_pix;

  // x^8+x^6+x^5+x^4+1, shift toward MSB with feedback into bit 0
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.start;

  // Both mux selects use one shared select bit-pair so the weights line up
  always_comb begin
    w_pb = 1'b0;
    w_nb = 1'b0;
    case (r_sel_lfsr[1:0])
      2'b00:   begin w_pb = (r_p3 > r_data_lfsr); w_nb = (r_p1 > r_data_lfsr); end
      2'b01,
      2'b10:   begin w_pb = (r_p6 > r_data_lfsr); w_nb = (r_p4 > r_data_lfsr); end
      default: begin w_pb = (r_p9 > r_data_lfsr); w_nb = (r_p7 > r_data_lfsr); end
    endcase
  end

  assign w_out_bit    = w_pb ^ w_nb;
  assign w_unused_pix = ^{r_p2, r_p8};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next_state = S_LOAD;
      S_LOAD:   w_next_state = S_RUN;
      S_RUN:    if (r_cycle == c_last_cycle) w_next_state = S_FINISH;
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p1        <= 8'd0;
      r_p2        <= 8'd0;
      r_p3        <= 8'd0;
      r_p4        <= 8'd0;
      r_p6        <= 8'd0;
      r_p7        <= 8'd0;
      r_p8        <= 8'd0;
      r_p9        <= 8'd0;
      r_data_lfsr <= DATA_SEED;
      r_sel_lfsr  <= SEL_SEED;
      r_ones      <= 9'd0;
      r_cycle     <= 9'd0;
      r_z         <= 8'd0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= (r_state == S_FINISH);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_p1        <= bus.pixel_1_bin;
            r_p2        <= bus.pixel_2_bin;
            r_p3        <= bus.pixel_3_bin;
            r_p4        <= bus.pixel_4_bin;
            r_p6        <= bus.pixel_6_bin;
            r_p7        <= bus.pixel_7_bin;
            r_p8        <= bus.pixel_8_bin;
            r_p9        <= bus.pixel_9_bin;
            r_data_lfsr <= DATA_SEED;
            r_sel_lfsr  <= SEL_SEED;
            r_ones      <= 9'd0;
            r_cycle     <= 9'd0;
            r_busy      <= 1'b1;
          end else begin
            // busy is still high only during the done cycle
            r_busy <= 1'b0;
          end
        end
        S_RUN: begin
          r_data_lfsr <= lfsr_step(r_data_lfsr);
          r_sel_lfsr  <= lfsr_step(r_sel_lfsr);
          r_ones      <= r_ones + {8'd0, w_out_bit};
          r_cycle     <= r_cycle + 9'd1;
        end
        S_FINISH: begin
          r_z <= r_ones[8] ? 8'hFF : r_ones[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.z_bin = r_z;
  assign bus.done  = r_done;
  assign bus.busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_stoch_sobel_x_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_stoch_sobel_x_engine : directed self-checking bench            |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_stoch_sobel_x_engine;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  stoch_sobel_x_engine_if bus_if ();

  stoch_sobel_x_engine #(
    .STREAM_LEN (256),
    .DATA_SEED  (8'h01),
    .SEL_SEED   (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Packed window order: {p1,p2,p3,p4,p6,p7,p8,p9}
  task automatic set_pix(input logic [63:0] w);
    bus_if.pixel_1_bin = w[63:56];
    bus_if.pixel_2_bin = w[55:48];
    bus_if.pixel_3_bin = w[47:40];
    bus_if.pixel_4_bin = w[39:32];
    bus_if.pixel_6_bin = w[31:24];
    bus_if.pixel_7_bin = w[23:16];
    bus_if.pixel_8_bin = w[15:8];
    bus_if.pixel_9_bin = w[7:0];
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return (v << 1) | {7'd0, fb};
  endfunction

  // Reference bit-stream evaluation of one window
  function automatic int model_z(input logic [63:0] w);
    logic [7:0] r, s, pos, neg;
    int cnt;
    r = 8'h01;
    s = 8'hA5;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (s[1:0] == 2'b00)      begin pos = w[47:40]; neg = w[63:56]; end
      else if (s[1:0] == 2'b11) begin pos = w[7:0];   neg = w[23:16]; end
      else                      begin pos = w[31:24]; neg = w[39:32]; end
      if ((pos > r) != (neg > r)) cnt++;
      r = nxt(r);
      s = nxt(s);
    end
    return (cnt > 255) ? 255 : cnt;
  endfunction

  task automatic run_window(input string tag, input logic [63:0] w, input int exp_z,
                            output int obs_z);
    int lat;
    set_pix(w);
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) begin lat = k; break; end
    end
    obs_z = int'(bus_if.z_bin);
    check({tag, "_latency"}, lat, 258);
    check({tag, "_z"}, bus_if.z_bin, exp_z);
    check({tag, "_busy_done"}, bus_if.busy, 1);
    @(posedge clk);
    #1;
    check({tag, "_done_clear"}, bus_if.done, 0);
    check({tag, "_busy_clear"}, bus_if.busy, 0);
  endtask

  initial begin
    int z;
    int m6;
    int d[3];
    int nd;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus_if.start = 1'b0;
    set_pix(64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_z", bus_if.z_bin, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_busy", bus_if.busy, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_window("flat", {8{8'h80}}, 0, z);
    run_window("step", {8'd0, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255}, 255, z);
    run_window("half", {8'd0, 8'd0, 8'd128, 8'd0, 8'd128, 8'd0, 8'd0, 8'd128}, 128, z);

    m6 = model_z({32'd0, 8'd255, 24'd0});
    run_window("p6_only", {32'd0, 8'd255, 24'd0}, m6, z);
    check("p6_range", (z >= 120 && z <= 136), 1);
    run_window("p4_only", {24'd0, 8'd255, 32'd0}, m6, z);

    // Start held high: three back-to-back windows
    set_pix({8'd0, 8'd0, 8'd128, 8'd0, 8'd128, 8'd0, 8'd0, 8'd128});
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    nd = 0;
    for (int t = 1; t <= 900; t++) begin
      @(posedge clk);
      #1;
      if (t == 400) check("b2b_z_hold", bus_if.z_bin, 128);
      if (bus_if.done) begin
        d[nd] = t;
        nd++;
        if (nd == 3) begin bus_if.start = 1'b0; break; end
      end
    end
    check("b2b_count", nd, 3);
    check("b2b_first", d[0], 258);
    check("b2b_gap1", d[1] - d[0], 259);
    check("b2b_gap2", d[2] - d[1], 259);
    @(posedge clk);
    #1;
    check("b2b_busy_clear", bus_if.busy, 0);

    // Start pulse and pixel change during RUN are both ignored
    set_pix({8'd0, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255});
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    nd = 0;
    for (int t = 1; t <= 600; t++) begin
      @(posedge clk);
      #1;
      if (t == 50) begin bus_if.start = 1'b1; set_pix({8{8'h80}}); end
      if (t == 51) bus_if.start = 1'b0;
      if (t == 100) check("ign_z_hold", bus_if.z_bin, 128);
      if (bus_if.done) begin
        nd++;
        if (nd == 1) begin
          check("ign_latency", t, 258);
          check("ign_z", bus_if.z_bin, 255);
        end
      end
    end
    check("ign_done_count", nd, 1);

    // Reset in the middle of RUN aborts the window
    set_pix({8'd0, 8'd0, 8'd128, 8'd0, 8'd128, 8'd0, 8'd0, 8'd128});
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    repeat (100) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_z", bus_if.z_bin, 0);
    check("abort_done", bus_if.done, 0);
    check("abort_busy", bus_if.busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) nd++;
    end
    check("abort_no_done", nd, 0);
    check("abort_idle_busy", bus_if.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
